pcs_tx_encoder: RTL and testbench

PCS_TX_ENCODER -- requirements
Module: pcs_tx_encoder

---
 rtl/pcs_tx_encoder.sv | 167 ++++++++++++++++
 tb/tb_pcs_tx_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_encoder.sv
// 64b/66b PCS transmit encoder.
// Stage 1 classifies the XGMII word and builds the candidate 66-bit block;
// stage 2 runs the TX state machine, substitutes EBLOCK on protocol errors
// and registers the outputs together with a saturating error-block count.
module pcs_tx_encoder #(
    parameter bit ERROR_ON_LPI = 1'b0
) (
    input  logic        i_txc,
    input  logic        i_reset_n,
    input  logic [63:0] i_xgmii_txd,
    input  logic [7:0]  i_xgmii_txc,
    input  logic        i_tx_pause,
    output logic [1:0]  o_tx_header,
    output logic [63:0] o_tx_data,
    output logic [15:0] o_err_count
);

    typedef enum logic [2:0] {BT_C, BT_S, BT_D, BT_T, BT_E} blk_type_t;
    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;

    localparam logic [1:0]  HDR_DATA    = 2'b10;
    localparam logic [1:0]  HDR_CTRL    = 2'b01;
    localparam logic [63:0] IDLE_BLOCK  = 64'h0000_0000_0000_001e;
    // Type 0x1e with the error code 0x1e in all eight 7-bit lanes.
    localparam logic [63:0] EBLOCK_DATA = 64'h3c78_f1e3_c78f_1e1e;
    localparam logic [7:0]  T_TYPES [8] = '{8'h87, 8'h99, 8'haa, 8'hb4,
                                            8'hcc, 8'hd2, 8'he1, 8'hff};

    function automatic logic is_valid_ctrl(input logic [7:0] c);
        return (c == 8'h07) || (c == 8'hfe) || ((c == 8'h06) && !ERROR_ON_LPI);
    endfunction

    function automatic logic [6:0] ctrl_code(input logic [7:0] c);
        case (c)
            8'h07:   return 7'h00;
            8'h06:   return 7'h06;
            default: return 7'h1e;
        endcase
    endfunction

    blk_type_t   enc_type, s1_type;
    logic [1:0]  enc_header, s1_header;
    logic [63:0] enc_data, s1_data;
    logic [7:0]  lane_valid, t_mask, t_above;
    logic [55:0] codes;
    tx_state_t   state, next_state;

    // Classify the current XGMII word and build its encoded block.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // can leave one unassigned and infer a latch.
        enc_type   = BT_E;
        enc_header = HDR_CTRL;
        enc_data   = EBLOCK_DATA;
        lane_valid = '0;
        codes      = '0;
        t_mask     = '0;
        t_above    = '0;
        for (int k = 0; k < 8; k++) begin
            lane_valid[k]   = is_valid_ctrl(i_xgmii_txd[8*k +: 8]);
            codes[7*k +: 7] = ctrl_code(i_xgmii_txd[8*k +: 8]);
        end
        if (i_xgmii_txc == 8'h00) begin
            enc_type   = BT_D;
            enc_header = HDR_DATA;
            enc_data   = i_xgmii_txd;
        end else if (i_xgmii_txc == 8'hff && (&lane_valid)) begin
            enc_type = BT_C;
            enc_data = {codes, 8'h1e};
        end else if (i_xgmii_txc == 8'h01 && i_xgmii_txd[7:0] == 8'hfb) begin
            enc_type = BT_S;
            enc_data = {i_xgmii_txd[63:8], 8'h78};
        end else if (i_xgmii_txc == 8'h1f && (&lane_valid[3:0]) &&
                     i_xgmii_txd[39:32] == 8'hfb) begin
            enc_type = BT_S;
            enc_data = {i_xgmii_txd[63:40], 4'h0, codes[27:0], 8'h33};
        end else if (i_xgmii_txc == 8'hf1 &&
                     (i_xgmii_txd[7:0] == 8'h9c || i_xgmii_txd[7:0] == 8'h5c) &&
                     i_xgmii_txd[63:32] == 32'h0707_0707) begin
            enc_type = BT_C;
            enc_data = {codes[55:28], (i_xgmii_txd[7:0] == 8'h5c) ? 4'hf : 4'h0,
                        i_xgmii_txd[31:8], 8'h4b};
        end else begin
            // Terminate in lane n: lanes below are data, lanes above valid control.
            for (int n = 0; n < 8; n++) begin
                t_mask  = 8'(8'hff << n);
                t_above = 8'(8'hfe << n);
                if (i_xgmii_txc == t_mask && i_xgmii_txd[8*n +: 8] == 8'hfd &&
                    (lane_valid & t_above) == t_above) begin
                    enc_type      = BT_T;
                    enc_data      = '0;
                    enc_data[7:0] = T_TYPES[n];
                    for (int i = 0; i < 7; i++) begin
                        if (i < n) enc_data[8 + 8*i +: 8] = i_xgmii_txd[8*i +: 8];
                    end
                    for (int k = 1; k < 8; k++) begin
                        if (k > n) enc_data[8 + 7*k +: 7] = codes[7*k +: 7];
                    end
                end
            end
        end
    end

    // Stage-1 register: holds the classified block, frozen while paused.
    always_ff @(posedge i_txc or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!i_reset_n) begin
            s1_type   <= BT_C;
            s1_header <= HDR_CTRL;
            s1_data   <= IDLE_BLOCK;
        end else if (!i_tx_pause) begin
            s1_type   <= enc_type;
            s1_header <= enc_header;
            s1_data   <= enc_data;
        end
    end

    // TX state register.
    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= TX_INIT;
        end else if (!i_tx_pause) begin
            state <= next_state;
        end
    end

    // Next-state decode from the current state and the stage-1 block type.
    always_comb begin
        next_state = TX_E;
        case (state)
            TX_INIT, TX_C, TX_T: begin
                if (s1_type == BT_C)      next_state = TX_C;
                else if (s1_type == BT_S) next_state = TX_D;
            end
            TX_D: begin
                if (s1_type == BT_D)      next_state = TX_D;
                else if (s1_type == BT_T) next_state = TX_T;
            end
            TX_E: begin
                if (s1_type == BT_D)      next_state = TX_D;
                else if (s1_type == BT_T) next_state = TX_T;
                else if (s1_type == BT_C) next_state = TX_C;
            end
            default: next_state = TX_E;
        endcase
    end

    // Output register: pass the stage-1 block or substitute EBLOCK and count it.
    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_tx_header <= HDR_CTRL;
            o_tx_data   <= IDLE_BLOCK;
            o_err_count <= '0;
        end else if (!i_tx_pause) begin
            if (next_state == TX_E) begin
                o_tx_header <= HDR_CTRL;
                o_tx_data   <= EBLOCK_DATA;
                if (o_err_count != 16'hffff) o_err_count <= o_err_count + 16'd1;
            end else begin
                o_tx_header <= s1_header;
                o_tx_data   <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_pcs_tx_encoder.sv
// Bench for pcs_tx_encoder: a byte-level reference model tracks the expected
// header/payload/count every cycle, and directed vectors pin literal results.
module tb_pcs_tx_encoder;

    localparam logic [63:0] EBLOCK = 64'h3c78_f1e3_c78f_1e1e;
    localparam int K_C = 0, K_S = 1, K_D = 2, K_T = 3, K_E = 4;
    localparam int ST_E = 4;

    typedef struct {
        int          kind;
        logic [1:0]  hdr;
        logic [63:0] data;
    } model_blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] txd = 64'h0707_0707_0707_0707;
    logic [7:0]  txc = 8'hff;
    logic        pause = 1'b0;
    logic [1:0]  o_hdr;
    logic [63:0] o_data;
    logic [15:0] o_err;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Successor state per (state, block kind); rows INIT,C,D,T,E, cols C,S,D,T,E.
    int trans [5][5] = '{'{1, 2, 4, 4, 4},
                         '{1, 2, 4, 4, 4},
                         '{4, 4, 2, 3, 4},
                         '{1, 2, 4, 4, 4},
                         '{1, 4, 2, 3, 4}};
    logic [7:0] t_types [8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};

    pcs_tx_encoder #(.ERROR_ON_LPI(1'b0)) dut (
        .i_txc       (clk),
        .i_reset_n   (rst_n),
        .i_xgmii_txd (txd),
        .i_xgmii_txc (txc),
        .i_tx_pause  (pause),
        .o_tx_header (o_hdr),
        .o_tx_data   (o_data),
        .o_err_count (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code_of(input logic [7:0] c);
        if (c == 8'hfe) return 7'h1e;
        if (c == 8'h06) return 7'h06;
        return 7'h00;
    endfunction

    // Encode one XGMII word straight from the block-format rules.
    function automatic model_blk_t model_encode(input logic [63:0] d, input logic [7:0] c);
        model_blk_t r;
        logic [7:0] b [8];
        bit v [8];
        bit ok;
        int n;
        r.kind = K_E;
        r.hdr  = 2'b01;
        r.data = EBLOCK;
        for (int i = 0; i < 8; i++) begin
            b[i] = d[8*i +: 8];
            v[i] = (b[i] == 8'h07) || (b[i] == 8'hfe) || (b[i] == 8'h06);
        end
        if (c == 8'h00) begin
            r.kind = K_D; r.hdr = 2'b10; r.data = d;
            return r;
        end
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (!v[i]) ok = 1'b0;
        if (c == 8'hff && ok) begin
            r.kind = K_C; r.data = 64'h1e;
            for (int i = 0; i < 8; i++) r.data[8 + 7*i +: 7] = code_of(b[i]);
            return r;
        end
        if (c == 8'h01 && b[0] == 8'hfb) begin
            r.kind = K_S; r.data = {d[63:8], 8'h78};
            return r;
        end
        if (c == 8'h1f && v[0] && v[1] && v[2] && v[3] && b[4] == 8'hfb) begin
            r.kind = K_S; r.data = 64'h33;
            for (int i = 0; i < 4; i++) r.data[8 + 7*i +: 7] = code_of(b[i]);
            r.data[63:40] = d[63:40];
            return r;
        end
        if (c == 8'hf1 && (b[0] == 8'h9c || b[0] == 8'h5c) &&
            b[4] == 8'h07 && b[5] == 8'h07 && b[6] == 8'h07 && b[7] == 8'h07) begin
            r.kind = K_C; r.data = 64'h4b;
            r.data[31:8]  = d[31:8];
            r.data[35:32] = (b[0] == 8'h5c) ? 4'hf : 4'h0;
            return r;
        end
        // Terminate lane is the first control lane.
        n = 0;
        while (n < 7 && !c[n]) n++;
        ok = (b[n] == 8'hfd);
        for (int i = 0; i < 8; i++) begin
            if (c[i] != (i >= n)) ok = 1'b0;
            if (i > n && !v[i]) ok = 1'b0;
        end
        if (ok) begin
            r.kind = K_T; r.data = '0;
            r.data[7:0] = t_types[n];
            for (int i = 0; i < n; i++) r.data[8 + 8*i +: 8] = b[i];
            for (int i = n + 1; i < 8; i++) r.data[8 + 7*i +: 7] = code_of(b[i]);
        end
        return r;
    endfunction

    model_blk_t  m_s1;
    int          m_state;
    logic [1:0]  m_hdr;
    logic [63:0] m_data;
    int          m_err;

    // Reference pipeline: stage-1 block, state, outputs and error count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1    <= '{K_C, 2'b01, 64'h1e};
            m_state <= 0;
            m_hdr   <= 2'b01;
            m_data  <= 64'h1e;
            m_err   <= 0;
        end else if (!pause) begin
            if (trans[m_state][m_s1.kind] == ST_E) begin
                m_hdr  <= 2'b01;
                m_data <= EBLOCK;
                if (m_err < 65535) m_err <= m_err + 1;
            end else begin
                m_hdr  <= m_s1.hdr;
                m_data <= m_s1.data;
            end
            m_state <= trans[m_state][m_s1.kind];
            m_s1    <= model_encode(txd, txc);
        end
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_block", {o_hdr, o_data}, {m_hdr, m_data});
            check("model_errcnt", {50'b0, o_err}, {34'b0, 32'(m_err)});
        end
    end

    task automatic check_out(input string name, input logic [1:0] h, input logic [63:0] d,
                             input logic [15:0] e);
        check({name, "_block"}, {o_hdr, o_data}, {h, d});
        check({name, "_errcnt"}, {50'b0, o_err}, {50'b0, e});
    endtask

    // Drive one word at negedge+1; it is captured on the next rising edge.
    task automatic send(input logic [63:0] d, input logic [7:0] c);
        txd = d; txc = c; pause = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic pause_cycle();
        txd = 64'hdead_beef_0bad_f00d; txc = 8'h00; pause = 1'b1;
        @(negedge clk); #1;
    endtask

    localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Idle after reset.
        send(IDLE_D, 8'hff);
        send(IDLE_D, 8'hff);
        check_out("idle", 2'b01, 64'h1e, 16'd0);

        // S0, data, T3 frame.
        send(64'hd555_5555_5555_55fb, 8'h01);
        send(64'h0123_4567_89ab_cdef, 8'h00);
        check_out("s0", 2'b01, 64'hd555_5555_5555_5578, 16'd0);
        send(64'h0707_0707_fdcc_bbaa, 8'hf8);
        check_out("data", 2'b10, 64'h0123_4567_89ab_cdef, 16'd0);
        send(IDLE_D, 8'hff);
        check_out("t3", 2'b01, 64'h0000_0000_ccbb_aab4, 16'd0);
        send(IDLE_D, 8'hff);

        // Data without start: EBLOCK, then idle recovers.
        send(64'h1111_2222_3333_4444, 8'h00);
        send(IDLE_D, 8'hff);
        check_out("eblock", 2'b01, EBLOCK, 16'd1);
        send(IDLE_D, 8'hff);
        check_out("recover", 2'b01, 64'h1e, 16'd1);

        // S4 frame ending in T7, ordered sets, S0 frame ending in T0.
        send(64'hccbb_aafb_0707_0707, 8'h1f);
        send(64'h5566_7788_99aa_bbcc, 8'h00);
        check_out("s4", 2'b01, 64'hccbb_aa00_0000_0033, 16'd1);
        send(64'hfd16_1514_1312_1110, 8'h80);
        check_out("data2", 2'b10, 64'h5566_7788_99aa_bbcc, 16'd1);
        send(IDLE_D, 8'hff);
        check_out("t7", 2'b01, 64'h1615_1413_1211_10ff, 16'd1);
        send(64'h0707_0707_3322_119c, 8'hf1);
        send(64'h0707_0707_3322_115c, 8'hf1);
        check_out("o0_9c", 2'b01, 64'h0000_0000_3322_114b, 16'd1);
        send(64'hd555_5555_5555_55fb, 8'h01);
        check_out("o0_5c", 2'b01, 64'h0000_000f_3322_114b, 16'd1);
        send(64'hfe07_0707_0707_07fd, 8'hff);
        send(IDLE_D, 8'hff);
        check_out("t0", 2'b01, 64'h3c00_0000_0000_0087, 16'd1);

        // Invalid control byte, then LPI idles.
        send(64'h0707_0707_0707_071c, 8'hff);
        send(64'h0606_0606_0606_0606, 8'hff);
        check_out("bad_ctrl", 2'b01, EBLOCK, 16'd2);
        send(IDLE_D, 8'hff);

        // Pause mid-frame: outputs frozen, no loss or duplication.
        send(64'hd555_5555_5555_55fb, 8'h01);
        send(64'haaaa_aaaa_aaaa_aaaa, 8'h00);
        for (int i = 0; i < 3; i++) begin
            pause_cycle();
            check_out("paused", 2'b01, 64'hd555_5555_5555_5578, 16'd2);
        end
        send(64'hbbbb_bbbb_bbbb_bbbb, 8'h00);
        check_out("after_pause_d1", 2'b10, 64'haaaa_aaaa_aaaa_aaaa, 16'd2);
        send(64'h0707_0707_0707_fd55, 8'hfe);
        check_out("after_pause_d2", 2'b10, 64'hbbbb_bbbb_bbbb_bbbb, 16'd2);
        send(IDLE_D, 8'hff);
        check_out("t1", 2'b01, 64'h0000_0000_0000_5599, 16'd2);
        send(IDLE_D, 8'hff);

        // Reset pulse mid-frame.
        send(64'hd555_5555_5555_55fb, 8'h01);
        send(64'hcccc_cccc_cccc_cccc, 8'h00);
        rst_n = 1'b0;
        #1 check_out("mid_reset", 2'b01, 64'h1e, 16'd0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        send(64'h1234_5678_9abc_def0, 8'h00);
        check_out("post_reset_idle", 2'b01, 64'h1e, 16'd0);
        send(IDLE_D, 8'hff);
        check_out("post_reset_eblock", 2'b01, EBLOCK, 16'd1);
        send(IDLE_D, 8'hff);
        send(IDLE_D, 8'hff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
